prg_ctr_stk: RTL and testbench

Parametrised program-counter unit for the CPU fetch stage: the next generation of the team's program counter. It adds configurable PC and offset widths, a hardware return-address stack for call/return, a pipeline stall, and an explicit IDLE/RUN/HALT run-control state machine. It drives the instruction-memory address and takes its control strobes from the decoder.

---
 rtl/prg_ctr_pkg.sv | 44 ++++
 rtl/prg_ctr_stk_if.sv | 37 +++
 rtl/ret_stack.sv | 46 ++++
 rtl/prg_ctr_stk.sv | 118 +++++++++++
 tb/tb_prg_ctr_stk.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/prg_ctr_pkg.sv
// Shared types for the program-counter unit: run states, PC operations,
// the decoded control strobe bundle and the priority encoder.
package prg_ctr_pkg;

  localparam int PC_W_DEF  = 16;
  localparam int OFF_W_DEF = 6;
  localparam int DEPTH_DEF = 4;

  // Encoded so that running/halted are single state bits.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HALT = 2'b10
  } run_state_t;

  typedef enum logic [2:0] {
    HOLD,
    INC,
    ABS,
    REL,
    CALL,
    RET
  } pc_op_t;

  typedef struct packed {
    logic stall;
    logic done;
    logic ret;
    logic call;
    logic abs_jump;
    logic rel_jump;
  } pc_ctrl_t;

  // Only one operation wins; lower-priority strobes are dropped entirely.
  function automatic pc_op_t pc_op_sel(input pc_ctrl_t c);
    if (c.stall || c.done) return HOLD;
    if (c.ret)             return RET;
    if (c.call)            return CALL;
    if (c.abs_jump)        return ABS;
    if (c.rel_jump)        return REL;
    return INC;
  endfunction

endpackage

// File: rtl/prg_ctr_stk_if.sv
// Decoder-facing bundle of the program-counter unit: control strobes in,
// PC and run/stack status out.
interface prg_ctr_stk_if
  import prg_ctr_pkg::*;
#(
  parameter int PC_W  = PC_W_DEF,
  parameter int OFF_W = OFF_W_DEF,
  parameter int DEPTH = DEPTH_DEF
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             start;
  logic             done;
  logic             stall;
  logic             abs_jump;
  logic             rel_jump;
  logic             call;
  logic             ret;
  logic [OFF_W-1:0] target;

  logic [PC_W-1:0]  PC;
  logic             running;
  logic             halted;
  logic [CW-1:0]    depth;
  logic             stack_err;

  modport master (
    output start, done, stall, abs_jump, rel_jump, call, ret, target,
    input  PC, running, halted, depth, stack_err
  );

  modport slave (
    input  start, done, stall, abs_jump, rel_jump, call, ret, target,
    output PC, running, halted, depth, stack_err
  );

endinterface

// File: rtl/ret_stack.sv
// Return-address LIFO. Pushes when full and pops when empty are ignored;
// the owner decides what those mean.
module ret_stack #(
  parameter int W     = 16,
  parameter int DEPTH = 4,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          clear,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [CW-1:0] cnt_q;
  logic [IW-1:0] wr_idx, rd_idx;

  assign wr_idx = IW'(cnt_q);
  assign rd_idx = IW'(cnt_q - CW'(1));
  assign full   = (cnt_q == CW'(DEPTH));
  assign empty  = (cnt_q == '0);
  assign count  = cnt_q;
  assign dout   = mem[rd_idx];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (push && !full) begin
      mem[wr_idx] <= din;
      cnt_q       <= cnt_q + CW'(1);
    end else if (pop && !empty) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

endmodule

// File: rtl/prg_ctr_stk.sv
// Fetch-stage program counter with IDLE/RUN/HALT run control, stall,
// absolute/relative jumps and a call/return stack.
module prg_ctr_stk
  import prg_ctr_pkg::*;
#(
  parameter int PC_W  = PC_W_DEF,
  parameter int OFF_W = OFF_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         reset,
  prg_ctr_stk_if.slave bus
);

  run_state_t      state_q, state_d;
  pc_ctrl_t        ctrl;
  pc_op_t          op;
  logic [PC_W-1:0] pc_q, pc_d, pc_inc, off_sx, tgt_zx, stk_top;
  logic            err_q, err_d;
  logic            in_run, start_ev, push, pop, full, empty;
  logic [CW-1:0]   cnt;

  assign in_run   = (state_q == RUN);
  assign start_ev = !in_run && bus.start;

  assign ctrl = '{stall:    bus.stall,
                  done:     bus.done,
                  ret:      bus.ret,
                  call:     bus.call,
                  abs_jump: bus.abs_jump,
                  rel_jump: bus.rel_jump};
  assign op   = in_run ? pc_op_sel(ctrl) : HOLD;

  // All PC arithmetic wraps modulo 2^PC_W.
  assign pc_inc = pc_q + PC_W'(1);
  assign off_sx = PC_W'($signed(bus.target));
  assign tgt_zx = PC_W'(bus.target);

  assign push = (op == CALL);
  assign pop  = (op == RET) && !empty;

  ret_stack #(.W(PC_W), .DEPTH(DEPTH)) u_stk (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .clear (start_ev),
    .din   (pc_inc),
    .dout  (stk_top),
    .full  (full),
    .empty (empty),
    .count (cnt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (bus.done && !bus.stall) state_d = HALT;
      HALT:    if (bus.start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.running   = (state_q == RUN);
    bus.halted    = (state_q == HALT);
    bus.PC        = pc_q;
    bus.depth     = cnt;
    bus.stack_err = err_q;
  end

  always_comb begin
    pc_d  = pc_q;
    err_d = err_q;
    if (start_ev) begin
      pc_d  = '0;
      err_d = 1'b0;
    end else begin
      case (op)
        INC:  pc_d = pc_inc;
        ABS:  pc_d = tgt_zx;
        REL:  pc_d = pc_q + off_sx;
        CALL: begin
          pc_d = tgt_zx;
          if (full) err_d = 1'b1;
        end
        // Underflow still advances so the program keeps fetching.
        RET: begin
          if (empty) begin
            pc_d  = pc_inc;
            err_d = 1'b1;
          end else begin
            pc_d = stk_top;
          end
        end
        default: pc_d = pc_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q  <= '0;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      err_q <= err_d;
    end
  end

endmodule

// File: tb/tb_prg_ctr_stk.sv
// Directed checks of the program-counter unit: a 16-bit instance for run
// control and the return stack, an 8-bit instance for wrap-around.
module tb_prg_ctr_stk;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  prg_ctr_stk_if #(.PC_W(16), .OFF_W(6), .DEPTH(4)) a ();
  prg_ctr_stk_if #(.PC_W(8),  .OFF_W(6), .DEPTH(4)) b ();

  prg_ctr_stk #(.PC_W(16), .OFF_W(6), .DEPTH(4)) dut_a (
    .clk(clk), .reset(reset), .bus(a.slave)
  );
  prg_ctr_stk #(.PC_W(8), .OFF_W(6), .DEPTH(4)) dut_b (
    .clk(clk), .reset(reset), .bus(b.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input int pc, input int dep, input int err);
    chk({tag, ".pc"},  32'(a.PC),        32'(pc));
    chk({tag, ".dep"}, 32'(a.depth),     32'(dep));
    chk({tag, ".err"}, 32'(a.stack_err), 32'(err));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_a();
    a.start = 0; a.done = 0; a.stall = 0; a.abs_jump = 0;
    a.rel_jump = 0; a.call = 0; a.ret = 0; a.target = '0;
  endtask

  task automatic clr_b();
    b.start = 0; b.done = 0; b.stall = 0; b.abs_jump = 0;
    b.rel_jump = 0; b.call = 0; b.ret = 0; b.target = '0;
  endtask

  initial begin
    clr_a();
    clr_b();
    #12;
    chk_a("rst", 0, 0, 0);
    chk("rst.run",  32'(a.running), 0);
    chk("rst.halt", 32'(a.halted),  0);
    reset = 0;

    // IDLE ignores everything but start
    a.rel_jump = 1; a.target = 6'd5; a.call = 1;
    step(); clr_a();
    chk_a("idle", 0, 0, 0);
    chk("idle.run", 32'(a.running), 0);

    a.start = 1; step(); clr_a();
    chk("start.pc",  32'(a.PC), 0);
    chk("start.run", 32'(a.running), 1);
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("inc.pc", 32'(a.PC), 32'(i));
    end

    a.done = 1; step(); clr_a();
    chk("done.halt", 32'(a.halted), 1);
    chk("done.run",  32'(a.running), 0);
    for (int i = 0; i < 5; i++) begin
      a.rel_jump = 1; a.target = 6'd7;
      step();
      chk("halt.pc", 32'(a.PC), 3);
    end
    clr_a();

    a.start = 1; step(); clr_a();
    chk("restart.pc", 32'(a.PC), 0);
    step();
    chk("restart.inc", 32'(a.PC), 1);

    // nested call / return
    a.call = 1; a.target = 6'd10; step();
    chk_a("call1", 10, 1, 0);
    a.target = 6'd20; step();
    chk_a("call2", 20, 2, 0);
    clr_a(); a.ret = 1; step();
    chk_a("ret1", 11, 1, 0);
    step(); clr_a();
    chk_a("ret2", 2, 0, 0);

    // stall beats call and done
    a.stall = 1; a.call = 1; a.target = 6'd30; step();
    chk_a("stall.call", 2, 0, 0);
    a.call = 0; a.done = 1; step(); clr_a();
    chk("stall.done.run", 32'(a.running), 1);
    chk("stall.done.pc",  32'(a.PC), 2);

    // ret wins over call and abs_jump, with no push side effect
    a.call = 1; a.target = 6'd40; step(); clr_a();
    chk_a("pcall", 40, 1, 0);
    a.ret = 1; a.call = 1; a.abs_jump = 1; a.target = 6'd50; step(); clr_a();
    chk_a("prio", 3, 0, 0);

    a.abs_jump = 1; a.target = 6'd33; step(); clr_a();
    chk("abs", 32'(a.PC), 33);
    a.rel_jump = 1; a.target = 6'd0; step();
    chk("rel0", 32'(a.PC), 33);
    a.target = 6'h3E; step(); clr_a();
    chk("relneg", 32'(a.PC), 31);
    a.call = 1; a.target = 6'd36; step();
    a.target = 6'd37; step(); clr_a();
    chk_a("pre.rst", 37, 2, 0);

    // asynchronous reset between edges
    #2 reset = 1;
    #1;
    chk_a("arst", 0, 0, 0);
    chk("arst.run", 32'(a.running), 0);
    chk("arst.halt", 32'(a.halted), 0);
    reset = 0;

    // overflow then underflow
    a.start = 1; step(); clr_a();
    chk("ov.start", 32'(a.PC), 0);
    for (int k = 0; k < 5; k++) begin
      a.call = 1; a.target = 6'(11 + k);
      step();
      chk_a("ov.call", 11 + k, (k < 4) ? k + 1 : 4, (k == 4) ? 1 : 0);
    end
    clr_a();
    a.ret = 1; step();
    chk_a("ov.ret1", 14, 3, 1);
    step();
    chk_a("ov.ret2", 13, 2, 1);
    step();
    chk_a("ov.ret3", 12, 1, 1);
    step();
    chk_a("ov.ret4", 1, 0, 1);
    step(); clr_a();
    chk_a("unf", 2, 0, 1);

    // start+done in RUN: done wins
    a.start = 1; a.done = 1; step(); clr_a();
    chk("sd.run.halt", 32'(a.halted), 1);
    chk_a("sd.run", 2, 0, 1);
    // start+done in HALT: start wins and clears the error
    a.start = 1; a.done = 1; step(); clr_a();
    chk("sd.halt.run", 32'(a.running), 1);
    chk_a("sd.halt", 0, 0, 0);

    // 8-bit wrap-around
    b.start = 1; step(); clr_b();
    chk("b.start", 32'(b.PC), 0);
    step(); step();
    chk("b.pc2", 32'(b.PC), 2);
    b.rel_jump = 1; b.target = 6'h3C; step(); clr_b();
    chk("b.relwrap", 32'(b.PC), 254);
    step();
    chk("b.255", 32'(b.PC), 255);
    b.call = 1; b.target = 6'd5; step(); clr_b();
    chk("b.call.pc",  32'(b.PC), 5);
    chk("b.call.dep", 32'(b.depth), 1);
    b.ret = 1; step(); clr_b();
    chk("b.ret.pc", 32'(b.PC), 0);
    b.rel_jump = 1; b.target = 6'h3F; step(); clr_b();
    chk("b.relm1", 32'(b.PC), 255);
    step();
    chk("b.incwrap", 32'(b.PC), 0);
    b.rel_jump = 1; b.target = 6'h3F; step();
    b.target = 6'd3; step(); clr_b();
    chk("b.relfwd", 32'(b.PC), 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
